// File: rtl/sdmac_fifo_pkg.sv
// Shared constants and byte-lane helpers for the SDMAC longword FIFO.
// Lane 0 is the most significant byte (bits 31:24).
package sdmac_fifo_pkg;

    localparam logic DIR_S2M = 1'b0;
    localparam logic DIR_M2S = 1'b1;

    localparam int SDMAC_FIFO_DEPTH = 8;

    localparam logic [1:0] LANE_MSB = 2'd0;
    localparam logic [1:0] LANE_LSB = 2'd3;

    function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sdmac_fifo_ram.sv
// DEPTH x 32 storage for the SDMAC FIFO: synchronous write, asynchronous read, no reset.
module sdmac_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdmac_fifo.sv
// Longword DMA FIFO with SCSI byte packer (DIR=0) / unpacker (DIR=1) and flush handling.
// Optional HALF watermark output is built when SDMAC_FIFO_WATERMARK_EN is defined.
module sdmac_fifo
    import sdmac_fifo_pkg::*;
#(
    parameter int DEPTH = SDMAC_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DIR,
    input  logic          CLR,
    input  logic          FLUSH,
    input  logic [7:0]    S_DIN,
    input  logic          S_WE,
    input  logic          S_RE,
    output logic [7:0]    S_DOUT,
    output logic          S_RDY,
    input  logic [31:0]   D_DIN,
    input  logic          D_WE,
    input  logic          D_RE,
    output logic [31:0]   D_DOUT,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   COUNT,
    output logic [1:0]    BPTR,
    output logic          FLUSH_DONE
`ifdef SDMAC_FIFO_WATERMARK_EN
    ,
    output logic          HALF
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    bptr_q, bptr_d, bptr_after;
    logic [31:0]   pack_q, pack_d, pack_after;
    logic          flush_pend_q, flush_pend_d;
    logic          flush_done_q, flush_done_d;
    logic          dir_q, dir_d;
    logic          push, pop, clr_all, full, empty, s_rdy;
    logic          s_we_acc, s_re_acc, d_we_acc, d_re_acc;
    logic [31:0]   push_data, head;

    sdmac_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (CLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (push_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign s_rdy = (DIR == DIR_S2M) ? (!flush_pend_q && (!full || bptr_q != LANE_LSB)) : !empty;

    always_comb begin
        dir_d        = DIR;
        // A direction change with data in flight behaves like CLR.
        clr_all      = CLR || ((DIR != dir_q) && (count_q != '0 || bptr_q != LANE_MSB));
        d_we_acc     = (DIR == DIR_M2S) && D_WE && !full;
        d_re_acc     = (DIR == DIR_S2M) && D_RE && !empty;
        s_we_acc     = (DIR == DIR_S2M) && S_WE && s_rdy;
        s_re_acc     = (DIR == DIR_M2S) && S_RE && s_rdy;
        push         = 1'b0;
        pop          = 1'b0;
        push_data    = D_DIN;
        pack_after   = pack_q;
        bptr_after   = bptr_q;
        pack_d       = pack_q;
        bptr_d       = bptr_q;
        flush_pend_d = flush_pend_q;
        flush_done_d = 1'b0;

        if (DIR == DIR_M2S) begin
            push = d_we_acc;
            pop  = s_re_acc && (bptr_q == LANE_LSB);
            if (s_re_acc) begin
                bptr_d = bptr_q + 2'd1;
            end
            flush_done_d = FLUSH;
        end else begin
            pop = d_re_acc;
            if (s_we_acc) begin
                if (bptr_q == LANE_LSB) begin
                    push       = 1'b1;
                    push_data  = {pack_q[31:8], S_DIN};
                    pack_after = '0;
                end else begin
                    pack_after = lane_put(pack_q, bptr_q, S_DIN);
                end
                bptr_after = bptr_q + 2'd1;
            end
            pack_d = pack_after;
            bptr_d = bptr_after;
            // The byte of this cycle is absorbed first; the flush sees the result.
            if (flush_pend_q) begin
                if (!full) begin
                    push         = 1'b1;
                    push_data    = pack_q;
                    pack_d       = '0;
                    bptr_d       = LANE_MSB;
                    flush_pend_d = 1'b0;
                    flush_done_d = 1'b1;
                end
            end else if (FLUSH) begin
                if (bptr_after == LANE_MSB) begin
                    flush_done_d = 1'b1;
                end else if (full) begin
                    flush_pend_d = 1'b1;
                end else begin
                    push         = 1'b1;
                    push_data    = pack_after;
                    pack_d       = '0;
                    bptr_d       = LANE_MSB;
                    flush_done_d = 1'b1;
                end
            end
        end

        if (clr_all) begin
            push         = 1'b0;
            pop          = 1'b0;
            pack_d       = '0;
            bptr_d       = LANE_MSB;
            flush_pend_d = 1'b0;
            flush_done_d = 1'b0;
        end

        wr_ptr_d = clr_all ? '0 : wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d = clr_all ? '0 : rd_ptr_q + {{(AW-1){1'b0}}, pop};
        count_d  = clr_all ? '0 : count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bptr_q       <= '0;
            pack_q       <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            dir_q        <= DIR_S2M;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            bptr_q       <= bptr_d;
            pack_q       <= pack_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            dir_q        <= dir_d;
        end
    end

`ifdef SDMAC_FIFO_WATERMARK_EN
    localparam logic [AW:0] HALF_C = DEPTH_C >> 1;
    logic half_q, half_d;

    always_comb begin
        half_d = (DIR == DIR_M2S) ? (count_d <= HALF_C) : (count_d >= HALF_C);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            half_q <= 1'b0;
        end else begin
            half_q <= half_d;
        end
    end

    assign HALF = half_q;
`endif

    assign S_DOUT     = empty ? 8'h00 : lane_get(head, bptr_q);
    assign S_RDY      = s_rdy;
    assign D_DOUT     = head;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign COUNT      = count_q;
    assign BPTR       = bptr_q;
    assign FLUSH_DONE = flush_done_q;

endmodule
